voice_allocator: RTL
====================

# voice_allocator

Polyphonic note scheduler that drives a bank of `oscillator` instances. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of `VOICES` voice slots. When every slot is busy it steals the oldest voice. Each slot's registered `enable`/`freq`/`amplitude`/`shape` outputs connect directly to one oscillator in the synth top level.

## Interface
Parameters:
- `VOICES`, 8, number of voice slots / oscillators (power of two, 2..32)
- `WIDTH`, 24, amplitude width, matching oscillator `WIDTH`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `ev_valid`  in  1  event present
- `ev_ready`  out  1  allocator can accept an event
- `ev_note_on`  in  1  1 = note-on, 0 = note-off
- `ev_key`  in  7  note number; identifies the note for retrigger and release
- `ev_freq`  in  16  oscillator frequency word for this note
- `ev_velocity`  in  7  note velocity
- `ev_shape`  in  `wave_shape`  waveform for this note
- `voice_enable`  out  `VOICES`  per-slot oscillator enable
- `voice_freq`  out  `[VOICES][16]`  per-slot frequency
- `voice_amplitude`  out  `[VOICES][WIDTH]`  per-slot amplitude
- `voice_shape`  out  `[VOICES]` `wave_shape`  per-slot waveform
- `stolen`  out  1  one-cycle pulse: the last note-on stole an active voice

## Operation
- Per-slot state: `active`, `key[6:0]`, `age[7:0]`, plus the registered output fields.
- FSM states:
  - IDLE: `ev_ready`=1. `ev_valid & ev_ready` latches the event, clears the candidates, sets scan index 0, and moves to SCAN.
  - SCAN: examines one slot per cycle, index 0..VOICES-1, tracking the candidates below. After index VOICES-1 the FSM moves to APPLY.
  - APPLY: commits the result and returns to IDLE.
- Candidates tracked during SCAN:
  - match: lowest-index active slot with `key == ev_key`.
  - free: lowest-index inactive slot.
  - oldest: active slot with maximum `age`; ties go to the lowest index.
- Note-on with `ev_velocity == 0` is treated as note-off.
- Note-on target:
  - Use match if present (retrigger). Otherwise use free. Otherwise use oldest (steal; `stolen` pulses).
  - Target slot: `active`=1, `key`, `freq`, `shape` loaded from the event, `age`=0.
  - Amplitude = `{1'b0, ev_velocity, (WIDTH-8)'b0}`, so velocity 127 at WIDTH=24 gives 8323072.
  - Every other active slot increments `age`, saturating at 255.
- Note-off: the match slot gets `active`=0 and `enable`=0. Its `freq`, `amplitude` and `shape` hold their values. No match means no state change and no error.
- `voice_enable[i]` always equals `active[i]`.

## Timing
- Reset values: `ev_ready`=0 while `rst` is high; all `voice_enable`=0, `voice_freq`=0, `voice_amplitude`=0, `voice_shape`=SIN, `age`=0, `key`=0, `stolen`=0, FSM in IDLE.
- Ready timing:
  - `ev_ready` is decoded from state == IDLE; it is 1 in the first cycle after `rst` falls.
  - Event data is sampled only on the accepting edge and may change afterwards.
- Latency: accept at edge E0, SCAN edges E1..E`VOICES`, APPLY edge E`VOICES`+1.
  - Outputs and `stolen` are valid after E`VOICES`+1.
  - `ev_ready` is high again in that same cycle.
- Throughput: one event per `VOICES`+2 cycles. A back-to-back event is accepted on the edge after APPLY.
- `stolen` is high for exactly the one cycle following APPLY.
- Reset during SCAN/APPLY discards the in-flight event; all state returns to reset values on that edge.
- Age saturation: a slot held at 255 stays at 255. Among several slots at 255, the lowest index is stolen.

## Structure
- `shape_pkg`: keeps `wave_shape`; add `KEY_W`=7, `VEL_W`=7, `FREQ_W`=16, and a `note_event_t` struct (`note_on`, `key`, `freq`, `velocity`, `shape`).
- Single module; slot state is held in flop arrays indexed by the scan counter.
- Natural sub-module: `voice_slot`, holding one slot's registers and its commit/age-increment logic, instantiated `VOICES` times. The FSM and candidate comparison stay in `voice_allocator`.

## Test plan
- Reset, then note-on key 60, freq 400, vel 127, SIN → after 10 cycles (VOICES=8) slot 0: enable=1, freq=400, amplitude=8323072; `ev_ready` low for exactly 9 cycles.
- Note-on keys 60, 62, 64 → slots 0, 1, 2 enabled; then note-off key 62 → only slot 1 disabled, slot 1 freq still set; re-note-on key 67 → lands in slot 1.
- Nine distinct note-ons with all 8 slots busy → ninth replaces slot 0 (oldest), `stolen` pulses one cycle, all other slots unchanged.
- Note-on key 60 twice (vel 127 then vel 32, freq 880) → same slot retriggered, amplitude=2097152, freq=880, no `stolen`; note-on vel 0 for key 60 → slot disabled.
- Note-off for an unallocated key → all outputs unchanged, `ev_ready` returns after 10 cycles; then assert `rst` mid-SCAN of a note-on → every output reads its reset value and the event is never applied.

Source files
------------

// File: rtl/shape_pkg.sv
// Shared waveform and note-event types for the oscillator bank and its voice allocator.
package shape_pkg;

  typedef enum logic [1:0] {
    SIN      = 2'd0,
    SQUARE   = 2'd1,
    SAW      = 2'd2,
    TRIANGLE = 2'd3
  } wave_shape;

  localparam int KEY_W  = 7;
  localparam int VEL_W  = 7;
  localparam int FREQ_W = 16;

  typedef struct packed {
    logic              note_on;
    logic [KEY_W-1:0]  key;
    logic [FREQ_W-1:0] freq;
    logic [VEL_W-1:0]  velocity;
    wave_shape         shape;
  } note_event_t;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: its registered oscillator controls, key tag and age counter.
module voice_slot
  import shape_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              note_off,
  input  logic              age_step,
  input  logic [KEY_W-1:0]  ld_key,
  input  logic [FREQ_W-1:0] ld_freq,
  input  logic [WIDTH-1:0]  ld_amp,
  input  wave_shape         ld_shape,
  output logic              active,
  output logic [KEY_W-1:0]  key,
  output logic [7:0]        age,
  output logic [FREQ_W-1:0] freq,
  output logic [WIDTH-1:0]  amplitude,
  output wave_shape         shape
);

  function automatic logic [7:0] age_sat_inc(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      key       <= '0;
      age       <= '0;
      freq      <= '0;
      amplitude <= '0;
      shape     <= SIN;
    end else if (load) begin
      active    <= 1'b1;
      key       <= ld_key;
      age       <= '0;
      freq      <= ld_freq;
      amplitude <= ld_amp;
      shape     <= ld_shape;
    end else begin
      // A released slot keeps freq/amplitude/shape so the oscillator output settles cleanly.
      if (note_off) active <= 1'b0;
      if (age_step && active) age <= age_sat_inc(age);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: scans the voice slots one per cycle, then retriggers,
// allocates a free slot, or steals the oldest voice.
module voice_allocator
  import shape_pkg::*;
#(
  parameter int VOICES = 8,
  parameter int WIDTH  = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_note_on,
  input  logic [KEY_W-1:0]               ev_key,
  input  logic [FREQ_W-1:0]              ev_freq,
  input  logic [VEL_W-1:0]               ev_velocity,
  input  wave_shape                      ev_shape,
  output logic [VOICES-1:0]              voice_enable,
  output logic [VOICES-1:0][FREQ_W-1:0]  voice_freq,
  output logic [VOICES-1:0][WIDTH-1:0]   voice_amplitude,
  output wave_shape                      voice_shape [VOICES],
  output logic                           stolen
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  note_event_t       ev;

  logic              match_found, free_found, old_found;
  logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
  logic [7:0]        old_age;

  logic [VOICES-1:0] slot_active;
  logic [KEY_W-1:0]  slot_key [VOICES];
  logic [7:0]        slot_age [VOICES];

  logic              is_on;
  logic              apply;
  logic [IDX_W-1:0]  tgt;
  logic [WIDTH-1:0]  ld_amp;

  assign ev_ready     = (state == IDLE) && !rst;
  assign voice_enable = slot_active;
  // Zero velocity on a note-on is the MIDI running-status form of note-off.
  assign is_on        = ev.note_on && (ev.velocity != '0);
  assign apply        = (state == APPLY);
  assign ld_amp       = {1'b0, ev.velocity, {(WIDTH-VEL_W-1){1'b0}}};

  always_comb begin
    tgt = old_idx;
    if (free_found)  tgt = free_idx;
    if (match_found) tgt = match_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      ev          <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      stolen      <= 1'b0;
    end else begin
      stolen <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_valid && ev_ready) begin
            ev          <= '{ev_note_on, ev_key, ev_freq, ev_velocity, ev_shape};
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            old_age     <= '0;
            idx         <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (slot_active[idx]) begin
            if (!match_found && slot_key[idx] == ev.key) begin
              match_found <= 1'b1;
              match_idx   <= idx;
            end
            // Strict greater-than keeps the lowest index among equal ages.
            if (!old_found || slot_age[idx] > old_age) begin
              old_found <= 1'b1;
              old_idx   <= idx;
              old_age   <= slot_age[idx];
            end
          end else if (!free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= idx + 1'b1;
          if (idx == IDX_W'(VOICES-1)) state <= APPLY;
        end
        APPLY: begin
          stolen <= is_on && !match_found && !free_found;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < VOICES; i++) begin : g_slot
    logic hit;
    logic off_hit;
    assign hit     = (tgt == IDX_W'(i));
    assign off_hit = match_found && (match_idx == IDX_W'(i));

    voice_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (apply && is_on && hit),
      .note_off  (apply && !is_on && off_hit),
      .age_step  (apply && is_on && !hit),
      .ld_key    (ev.key),
      .ld_freq   (ev.freq),
      .ld_amp    (ld_amp),
      .ld_shape  (ev.shape),
      .active    (slot_active[i]),
      .key       (slot_key[i]),
      .age       (slot_age[i]),
      .freq      (voice_freq[i]),
      .amplitude (voice_amplitude[i]),
      .shape     (voice_shape[i])
    );
  end

endmodule
